// File: rtl/tnet_rx_decoder.sv
// tnet_rx_decoder: decodes Aurora RX words into local control pulses and forwards
// ring traffic not addressed exclusively to this node through a small TX FIFO.
module tnet_rx_decoder #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] MAX_HOP    = 8'd15
) (
   input  logic         user_clk_i,
   input  logic         user_rst_i,
   input  logic [7:0]   my_id_i,
   input  logic         channel_up_i,
   input  logic [127:0] s_axi_rx_tdata,
   input  logic         s_axi_rx_tvalid,
   output logic [127:0] m_axi_tx_tdata,
   output logic         m_axi_tx_tvalid,
   input  logic         m_axi_tx_tready,
   output logic         time_rst_o,
   output logic         time_init_o,
   output logic         time_updt_o,
   output logic         start_o,
   output logic         pause_o,
   output logic         stop_o,
   output logic [31:0]  time_off_dt_o,
   output logic [31:0]  rx_cnt_o,
   output logic [15:0]  drop_cnt_o,
   output logic [15:0]  err_cnt_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   typedef enum logic {DOWN, UP} state_t;
   state_t state_q, state_d;
   logic [4:0]   op;
   logic [7:0]   dst, src, hop;
   logic         up, rx, local_hit, known, fwd, full, pop, push;
   logic [127:0] fwd_word;
   logic [127:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]  count;
   logic [5:0]   pulse_q, pulse_d;
   always_ff @(posedge user_clk_i) state_q <= user_rst_i ? DOWN : state_d;
   always_comb begin
      state_d = channel_up_i ? UP : DOWN;
      op = s_axi_rx_tdata[127:123];
      dst = s_axi_rx_tdata[122:115];
      src = s_axi_rx_tdata[114:107];
      hop = s_axi_rx_tdata[106:99];
      // A word arriving on the edge where the channel drops is discarded with the flush
      up = (state_q == UP) && channel_up_i;
      rx = up && s_axi_rx_tvalid;
      known = (op >= 5'd1) && (op <= 5'd6);
      local_hit = rx && (dst == my_id_i || dst == 8'hFF);
      fwd = rx && dst != my_id_i && src != my_id_i && hop < MAX_HOP;
      fwd_word = {s_axi_rx_tdata[127:107], hop + 8'd1, s_axi_rx_tdata[98:0]};
      full = count == FULL;
      pop = m_axi_tx_tvalid && m_axi_tx_tready;
      push = fwd && (!full || pop);
      pulse_d = (local_hit && known) ? 6'b1 << (op - 5'd1) : 6'b0;
   end
   assign m_axi_tx_tvalid = count != '0;
   assign m_axi_tx_tdata = m_axi_tx_tvalid ? mem[rd_ptr] : '0;
   assign {stop_o, pause_o, start_o, time_updt_o, time_init_o, time_rst_o} = pulse_q;
   always_ff @(posedge user_clk_i) if (push) mem[wr_ptr] <= fwd_word;
   always_ff @(posedge user_clk_i) begin
      if (user_rst_i || !up) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge user_clk_i) begin
      if (user_rst_i) begin
         pulse_q <= '0;
         time_off_dt_o <= '0;
         rx_cnt_o <= '0;
         drop_cnt_o <= '0;
         err_cnt_o <= '0;
      end else begin
         pulse_q <= pulse_d;
         if (local_hit && op == 5'd3) time_off_dt_o <= s_axi_rx_tdata[95:64];
         if (rx) rx_cnt_o <= rx_cnt_o + 32'd1;
         if (fwd && full && !pop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
         if (local_hit && !known && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
      end
   end
endmodule

// File: tb/tb_tnet_rx_decoder.sv
// tb_tnet_rx_decoder: directed vectors with hand-computed expectations for the RX decoder.
module tb_tnet_rx_decoder;
   logic         clk = 0, rst = 1, channel_up = 0, rx_valid = 0, tx_ready = 0;
   logic [7:0]   my_id = 8'h03;
   logic [127:0] rx_data = '0, tx_data;
   logic         tx_valid;
   logic         time_rst, time_init, time_updt, start, pause, stop;
   logic [31:0]  time_off, rx_cnt;
   logic [15:0]  drop_cnt, err_cnt;
   logic [5:0]   pulses;
   logic [127:0] exp_q [5];
   int           vectors = 0, miscompares = 0;
   tnet_rx_decoder #(.FIFO_DEPTH(4), .MAX_HOP(8'd15)) dut (
      .user_clk_i(clk), .user_rst_i(rst), .my_id_i(my_id), .channel_up_i(channel_up),
      .s_axi_rx_tdata(rx_data), .s_axi_rx_tvalid(rx_valid),
      .m_axi_tx_tdata(tx_data), .m_axi_tx_tvalid(tx_valid), .m_axi_tx_tready(tx_ready),
      .time_rst_o(time_rst), .time_init_o(time_init), .time_updt_o(time_updt),
      .start_o(start), .pause_o(pause), .stop_o(stop), .time_off_dt_o(time_off),
      .rx_cnt_o(rx_cnt), .drop_cnt_o(drop_cnt), .err_cnt_o(err_cnt)
   );
   always #5 clk = ~clk;
   assign pulses = {stop, pause, start, time_updt, time_init, time_rst};
   function automatic logic [127:0] mk(input logic [4:0] op, input logic [7:0] dst, src, hop, input logic [31:0] dt1);
      return {op, dst, src, hop, 3'b000, dt1, 32'hAAAA5555, 32'h00000F0F};
   endfunction
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(negedge clk);
   endtask
   task automatic send(input logic [127:0] w);
      rx_data = w;
      rx_valid = 1;
      cyc();
      rx_valid = 0;
   endtask
   initial begin
      cyc(); cyc();
      chk("rst_pulses", 128'(pulses), 0);
      chk("rst_tvalid", 128'(tx_valid), 0);
      chk("rst_tdata", tx_data, 0);
      chk("rst_rxcnt", 128'(rx_cnt), 0);
      chk("rst_off", 128'(time_off), 0);
      rst = 0;
      channel_up = 1;
      cyc();
      send(mk(5'd3, 8'h03, 8'h01, 8'd0, 32'h1234));
      chk("updt_pulse", 128'(pulses), 6'b000100);
      chk("updt_off", 128'(time_off), 32'h1234);
      chk("updt_tvalid", 128'(tx_valid), 0);
      chk("updt_rxcnt", 128'(rx_cnt), 1);
      cyc();
      chk("updt_single", 128'(pulses), 0);
      send(mk(5'd4, 8'hFF, 8'h01, 8'd2, 32'h0));
      chk("bc_pulse", 128'(pulses), 6'b001000);
      chk("bc_tvalid", 128'(tx_valid), 1);
      chk("bc_tdata", tx_data, mk(5'd4, 8'hFF, 8'h01, 8'd3, 32'h0));
      tx_ready = 1;
      cyc();
      tx_ready = 0;
      chk("bc_popped", 128'(tx_valid), 0);
      for (int i = 0; i < 6; i++) send(mk(5'd1, 8'h05, 8'h01, 8'(i), 32'(i)));
      chk("full_drop", 128'(drop_cnt), 2);
      chk("full_head", tx_data, mk(5'd1, 8'h05, 8'h01, 8'd1, 32'd0));
      chk("fwd_no_pulse", 128'(pulses), 0);
      for (int i = 0; i < 4; i++) exp_q[i] = mk(5'd1, 8'h05, 8'h01, 8'(i + 1), 32'(i));
      exp_q[4] = mk(5'd1, 8'h05, 8'h01, 8'd7, 32'd6);
      tx_ready = 1;
      send(mk(5'd1, 8'h05, 8'h01, 8'd6, 32'd6));
      chk("full_rw_drop", 128'(drop_cnt), 2);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("drain%0d_valid", i), 128'(tx_valid), 1);
         chk($sformatf("drain%0d_data", i), tx_data, exp_q[i]);
         cyc();
      end
      chk("drain_empty", 128'(tx_valid), 0);
      chk("drain_rxcnt", 128'(rx_cnt), 9);
      tx_ready = 0;
      send(mk(5'd1, 8'h05, 8'h03, 8'd0, 32'd0));
      chk("loop_nofwd", 128'(tx_valid), 0);
      send(mk(5'd1, 8'h05, 8'h01, 8'd15, 32'd0));
      chk("hopmax_nofwd", 128'(tx_valid), 0);
      chk("ring_drop", 128'(drop_cnt), 2);
      send(mk(5'd1, 8'h05, 8'h01, 8'd14, 32'd0));
      chk("hop14_fwd", tx_data, mk(5'd1, 8'h05, 8'h01, 8'd15, 32'd0));
      tx_ready = 1;
      cyc();
      tx_ready = 0;
      send(mk(5'd9, 8'h03, 8'h01, 8'd0, 32'd0));
      chk("unk_err", 128'(err_cnt), 1);
      chk("unk_pulse", 128'(pulses), 0);
      chk("unk_rxcnt", 128'(rx_cnt), 13);
      for (int i = 0; i < 3; i++) send(mk(5'd1, 8'h07, 8'h01, 8'd0, 32'd0));
      chk("loss_queued", 128'(tx_valid), 1);
      channel_up = 0;
      cyc();
      chk("loss_flush", 128'(tx_valid), 0);
      send(mk(5'd4, 8'hFF, 8'h01, 8'd0, 32'd0));
      chk("down_rxcnt", 128'(rx_cnt), 16);
      chk("down_pulse", 128'(pulses), 0);
      chk("down_tvalid", 128'(tx_valid), 0);
      channel_up = 1;
      cyc();
      chk("reup_empty", 128'(tx_valid), 0);
      send(mk(5'd1, 8'h09, 8'h01, 8'd4, 32'h55));
      chk("reup_head", tx_data, mk(5'd1, 8'h09, 8'h01, 8'd5, 32'h55));
      chk("reup_rxcnt", 128'(rx_cnt), 17);
      rst = 1;
      rx_data = mk(5'd2, 8'h03, 8'h01, 8'd0, 32'd0);
      rx_valid = 1;
      cyc();
      rx_valid = 0;
      chk("mrst_pulses", 128'(pulses), 0);
      chk("mrst_tvalid", 128'(tx_valid), 0);
      chk("mrst_tdata", tx_data, 0);
      chk("mrst_cnts", {rx_cnt, drop_cnt, err_cnt, time_off}, 0);
      rst = 0;
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tnet_rx_decoder.md
# tnet_rx_decoder

Receive-side packet decoder for the timing network. Sits between the Aurora RX user interface (128-bit stream, no backpressure) and the tProc time/control outputs. It decodes each received word into single-cycle control pulses for the local node. It also re-queues packets not addressed exclusively to this node into a small FIFO that drives the Aurora TX user interface (valid/ready handshake). This closes the ring: the RX of one node feeds the TX toward the next.

## Interface
Parameters:
- FIFO_DEPTH, 4: forward FIFO depth in 128-bit words; power of two, 2..16.
- MAX_HOP, 8'd15: packets arriving with hop >= MAX_HOP are not forwarded.

Ports:
- user_clk_i  in  1  Aurora user clock; the only clock of the block.
- user_rst_i  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- my_id_i  in  8  node address; quasi-static.
- channel_up_i  in  1  Aurora channel status.
- s_axi_rx_tdata  in  128  received word.
- s_axi_rx_tvalid  in  1  word valid; no ready, every valid word must be consumed.
- m_axi_tx_tdata  out  128  forwarded word.
- m_axi_tx_tvalid  out  1  forward valid.
- m_axi_tx_tready  in  1  TX accepts.
- time_rst_o, time_init_o, time_updt_o, start_o, pause_o, stop_o  out  1 each  one-cycle pulses.
- time_off_dt_o  out  32  offset, loaded on time_updt.
- rx_cnt_o  out  32  valid words received, wraps.
- drop_cnt_o  out  16  forwards dropped, saturating.
- err_cnt_o  out  16  unknown-op packets for this node, saturating.

## Operation
- Word format: [127:123] op, [122:115] dst, [114:107] src, [106:99] hop, [98:96] reserved, [95:64] dt1, [63:32] dt2, [31:0] dt3. dst 8'hFF is broadcast.
- Ops: 1 time_rst, 2 time_init, 3 time_updt (time_off_dt_o <= dt1), 4 start, 5 pause, 6 stop; all other values are unknown.
- Enable state machine:
  - DOWN: rx ignored, FIFO flushed, m_axi_tx_tvalid=0.
  - DOWN->UP when channel_up_i=1 is sampled.
  - UP->DOWN when channel_up_i=0 is sampled; flush at that edge, any in-flight word is lost.
- Local action, in UP with valid word: if dst==my_id_i or dst==8'hFF, pulse the op's output. If the op is unknown, increment err_cnt_o instead.
- Forward, in UP with valid word: required when dst!=my_id_i AND src!=my_id_i AND hop<MAX_HOP.
  - Broadcast is both acted on and forwarded.
  - Forwarded word equals the received word with hop+1; all other fields unchanged.
  - If the FIFO is full, the word is dropped and drop_cnt_o increments.
  - src==my_id_i (ring loop) or hop>=MAX_HOP drops silently; no count.
- rx_cnt_o counts every valid word sampled in UP.

## Timing
- Reset values: all pulses 0, time_off_dt_o 0, counters 0, m_axi_tx_tvalid 0, m_axi_tx_tdata 0, FIFO empty, state DOWN.
- Decode latency: word sampled at edge N gives its pulse high for exactly the cycle after edge N (registered output).
- Pulses from back-to-back words may be high on consecutive cycles.
- time_off_dt_o updates at the same edge time_updt_o rises.
- FIFO write at edge N; if the FIFO was empty, m_axi_tx_tvalid=1 from edge N.
- m_axi_tx_tdata and tvalid are held stable until tvalid&&tready; then the next entry is presented in the following cycle with no bubble.
- Write and read in the same cycle when full: the read frees space first, so the write succeeds.
- Throughput: one word per cycle in and out.
- Counter rules: drop_cnt_o and err_cnt_o stick at 16'hFFFF; rx_cnt_o wraps 32'hFFFFFFFF->0.
- Reset mid-operation clears everything within the same edge.

## Test plan
- Local decode: my_id=8'h03, channel up, word op=3 dst=03 src=01 hop=0 dt1=32'h1234 → time_updt_o pulse for 1 cycle, time_off_dt_o=32'h1234, m_axi_tx_tvalid stays 0, rx_cnt_o=1.
- Broadcast: op=4 dst=FF src=01 hop=2 → start_o pulse, and FIFO output equals the input with hop=3, presented the cycle after sampling.
- Backpressure and full: tready=0, 6 forwardable words back-to-back, FIFO_DEPTH=4 → 4 queued, drop_cnt_o=2. Then tready=1 → 4 words out in 4 consecutive cycles in order.
- Ring drops: src=my_id, and separately hop=15 → no forward, drop_cnt_o unchanged; unknown op=9 dst=03 → err_cnt_o=1, no pulse.
- Channel loss: 3 words queued, channel_up_i→0 → m_axi_tx_tvalid=0 next cycle. Words sent while down → rx_cnt_o unchanged. Channel up again → FIFO empty.
- Reset mid-stream: assert user_rst_i while tvalid=1 and FIFO non-empty → all outputs and counters at reset values after one edge.
